alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
Multi-cycle 16x16 unsigned shift-and-add multiplier. It acts as the initiator side of the 16-bit ALU operand/result interface: it drives A, B and ALU_op (add only) into the existing clocked ALU and consumes its result. It sits beside the ALU in the datapath and gives the processor a MUL capability without a dedicated multiplier array. The output is the low 16 bits of the product plus zero/negative flags.

Parameters:
ALU_LAT, 1, clock cycles from stable ALU operands to valid alu_result (0 = combinational ALU).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
mcand  input  16  multiplicand, sampled when start is accepted
mplier  input  16  multiplier, sampled when start is accepted
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse in DONE state
product  output  16  low 16 bits of mcand*mplier, held until the next accepted start
zero  output  1  product == 0, held with product
neg  output  1  product[15], held with product
alu_a  output  16  ALU operand A (accumulator)
alu_b  output  16  ALU operand B (shifted multiplicand)
alu_op  output  2  ALU opcode, always 2'b00 (add)
alu_result  input  16  ALU result

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy, done, product, zero, neg, alu_a, alu_b and alu_op all 0; internal acc, a_reg and b_reg all 0. Reset wins over every other event, including mid-operation. An aborted operation produces no done pulse.
- Clock and reset naming: one clock; reset is synchronous and active-high (ports clk, rst).
- State machine: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE: if start=1, load a_reg=mcand, b_reg=mplier and acc=0, then go to CHECK. The start level is otherwise ignored. start is ignored in all non-IDLE states.
- CHECK:
  - If b_reg==0, go to DONE.
  - Else if b_reg[0]==0: a_reg<<=1, b_reg>>=1, stay in CHECK (1 cycle per zero bit).
  - Else: register alu_a=acc, alu_b=a_reg, alu_op=00, then go to ISSUE.
- ISSUE: 1 cycle with operands held stable. If ALU_LAT==0, sample at the end of ISSUE and do the capture action below. Otherwise go to WAIT.
- WAIT: held for ALU_LAT cycles with operands stable. At the end of the last WAIT cycle do the capture action and go to CHECK.
- Capture action: acc<=alu_result, a_reg<<=1, b_reg>>=1.
- DONE: register product=acc, zero=(acc==0), neg=acc[15]; done=1 for this cycle only; then go to IDLE. A start during DONE is ignored.
- alu_a and alu_b hold their last values outside ISSUE/WAIT. alu_op is constant 00 after reset.
- Arithmetic: modulo 2^16. Bits shifted out of a_reg and ALU carries are discarded, so the result is truncated with no overflow flag.
- Latency (cycles after the start-accept edge, ALU_LAT=L):
  - CHECK pass per zero bit: 1 cycle.
  - Per one bit: 1 CHECK + 1 ISSUE + L cycles.
  - Final CHECK: 1 cycle; DONE: 1 cycle.
  - Termination is early, once no set bits remain in b_reg.
- busy is 0 in IDLE and 1 in CHECK/ISSUE/WAIT/DONE.

Test Plan:
- Reset mid-operation: start with mcand=3, mplier=5; assert rst in cycle 4 -> next cycle busy=0, done never pulses, product=0; then a fresh start with 3*5 completes normally.
- mcand=3, mplier=5, ALU_LAT=1 -> alu_a/alu_b presentations are (0,3) then (3,12); done pulses in cycle 9 after accept; product=0x000F, zero=0, neg=0; start pulses while busy are ignored.
- mplier=0, mcand=0x1234 -> no ALU ops issued; done in cycle 2; product=0x0000, zero=1.
- mcand=0xFFFF, mplier=0xFFFF -> product=0x0001 (truncated), zero=0, neg=0; 16 ALU adds observed.
- mcand=0x0100, mplier=0x0100 -> product=0x0000 (wrap), zero=1. Then mcand=3, mplier=0x5555 -> product=0xFFFF, neg=1.
- Back-to-back: start held high continuously -> a new operation is accepted only in the IDLE cycle following DONE. product holds the old value until the next DONE.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 16x16 unsigned shift-and-add multiplier (low 16 bits).
// Drives an external clocked ALU with add operations and accumulates its results.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request, accepted only while idle
//   mcand, mplier    operands, sampled when start is accepted
//   busy             high from the cycle after accept through the DONE cycle
//   done             one-cycle pulse in the DONE cycle
//   product/zero/neg truncated product and its flags, held until the next DONE
//   alu_a, alu_b     ALU operands (accumulator, shifted multiplicand)
//   alu_op           ALU opcode, always add (2'b00)
//   alu_result       ALU result, valid ALU_LAT cycles after operands are stable
module alu_mul_seq #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zero,
    output logic        neg,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t        state_q;
    logic [15:0]   acc_q;
    logic [15:0]   a_q;
    logic [15:0]   b_q;
    logic [CW-1:0] wcnt_q;
    logic          busy_q;
    logic          done_q;
    logic [15:0]   product_q;
    logic          zero_q;
    logic          neg_q;
    logic [15:0]   alu_a_q;
    logic [15:0]   alu_b_q;
    logic [1:0]    alu_op_q;

    // Per-bit step: the bit shifted out of a_q is dropped (mod 2^16).
    logic [15:0] a_d;
    logic [15:0] b_d;

    assign a_d = {a_q[14:0], 1'b0};
    assign b_d = {1'b0, b_q[15:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= mcand;
                        b_q     <= mplier;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (b_q == 16'd0) begin
                        // Results are registered on entry so they are
                        // already valid while done is high.
                        product_q <= acc_q;
                        zero_q    <= (acc_q == 16'd0);
                        neg_q     <= acc_q[15];
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (!b_q[0]) begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end else begin
                        alu_a_q  <= acc_q;
                        alu_b_q  <= a_q;
                        alu_op_q <= 2'b00;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ALU_LAT == 0) begin
                        acc_q   <= alu_result;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        state_q <= S_CHECK;
                    end else begin
                        wcnt_q  <= CW'(ALU_LAT - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        acc_q   <= alu_result;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        state_q <= S_CHECK;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign zero    = zero_q;
    assign neg     = neg_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq with a clocked add ALU.
// Table vectors, randomized operations and hand-written corner sequences.
module tb_alu_mul_seq;

    localparam int L = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;
    logic        neg;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;

    int n_cmp;
    int n_bad;

    logic [15:0] last_prod;
    logic        last_zero;
    logic        last_neg;

    alu_mul_seq #(.ALU_LAT(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .zero       (zero),
        .neg        (neg),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency ALU; any opcode other than add yields garbage.
    always_ff @(posedge clk) begin
        alu_result <= (alu_op == 2'b00) ? alu_a + alu_b : 16'hDEAD;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: product from plain multiplication; the expected operand
    // presentations and DONE cycle come from walking the multiplier bits.
    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                          input bit noise, input bit hold, input string nm);
        logic [31:0] full;
        logic [15:0] acc;
        logic [15:0] a;
        logic [15:0] exa [128];
        logic [15:0] exb [128];
        bit          exv [128];
        int          k;
        int          exp_k;
        int          bad;
        bit          seen;
        for (int i = 0; i < 128; i++) exv[i] = 1'b0;
        full = {16'd0, mc} * {16'd0, mp};
        acc = '0;
        a = mc;
        k = 1;
        for (int i = 0; i < 16; i++) begin
            if ((mp >> i) == 16'd0) break;
            if (mp[i]) begin
                for (int j = 0; j <= L; j++) begin
                    exa[k + 1 + j] = acc;
                    exb[k + 1 + j] = a;
                    exv[k + 1 + j] = 1'b1;
                end
                acc = acc + a;
                k += 2 + L;
            end else begin
                k += 1;
            end
            a = a << 1;
        end
        exp_k = k + 1;

        @(negedge clk);
        chk({nm, ":idle_busy"}, 32'(busy), 32'd0);
        chk({nm, ":idle_done"}, 32'(done), 32'd0);
        chk({nm, ":held_prod"}, 32'(product), 32'(last_prod));
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        @(posedge clk);
        #1;
        start = 1'b0;
        bad = 0;
        seen = 1'b0;
        for (int c = 1; c <= exp_k + 8 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                chk({nm, ":done_cycle"}, 32'(c), 32'(exp_k));
                chk({nm, ":busy_at_done"}, 32'(busy), 32'd1);
                chk({nm, ":product"}, 32'(product), 32'(full[15:0]));
                chk({nm, ":zero"}, 32'(zero), 32'(full[15:0] == 16'd0));
                chk({nm, ":neg"}, 32'(neg), 32'(full[15]));
            end else begin
                if (busy !== 1'b1 || product !== last_prod) bad++;
                if (alu_op !== 2'b00) bad++;
                if (c < 128 && exv[c] &&
                    (alu_a !== exa[c] || alu_b !== exb[c])) bad++;
            end
            if (noise) begin
                start  = 1'($urandom);
                mcand  = 16'($urandom);
                mplier = 16'($urandom);
            end
        end
        start = hold;
        if (!seen) chk({nm, ":done_timeout"}, 32'd0, 32'd1);
        chk({nm, ":trace_bad_cycles"}, 32'(bad), 32'd0);
        last_prod = full[15:0];
        last_zero = (full[15:0] == 16'd0);
        last_neg  = full[15];
    endtask

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        bit          noise;
        logic [15:0] prod;
        bit          z;
        bit          n;
    } vec_t;

    vec_t vt [5];

    initial begin
        int dcount;
        vt[0] = '{16'h0003, 16'h0005, 1'b1, 16'h000F, 1'b0, 1'b0};
        vt[1] = '{16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[3] = '{16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[4] = '{16'h0003, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1};

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        mcand = '0;
        mplier = '0;
        last_prod = '0;
        last_zero = 1'b0;
        last_neg = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:product", 32'(product), 32'd0);
        chk("rst:zero", 32'(zero), 32'd0);
        chk("rst:neg", 32'(neg), 32'd0);
        chk("rst:alu_a", 32'(alu_a), 32'd0);
        chk("rst:alu_b", 32'(alu_b), 32'd0);
        chk("rst:alu_op", 32'(alu_op), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(vt[i].mc, vt[i].mp, vt[i].noise, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d:tbl_prod", i), 32'(product), 32'(vt[i].prod));
            chk($sformatf("vec%0d:tbl_zero", i), 32'(zero), 32'(vt[i].z));
            chk($sformatf("vec%0d:tbl_neg", i), 32'(neg), 32'(vt[i].n));
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] m;
            m = (i % 3 == 0) ? 16'($urandom) : 16'($urandom) & 16'($urandom);
            run_op(16'($urandom), m, 1'($urandom), 1'b0, $sformatf("rnd%0d", i));
        end

        // start held high: second op accepted only in the IDLE after DONE
        run_op(16'h1234, 16'h0003, 1'b0, 1'b1, "b2b_first");
        run_op(16'h0007, 16'h0009, 1'b0, 1'b1, "b2b_second");
        run_op(16'h00A5, 16'h8001, 1'b0, 1'b0, "b2b_third");

        // reset during an operation
        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'd3;
        mplier = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        @(negedge clk);
        if (done === 1'b1) dcount++;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:product", 32'(product), 32'd0);
        chk("midrst:zero", 32'(zero), 32'd0);
        chk("midrst:alu_a", 32'(alu_a), 32'd0);
        chk("midrst:alu_b", 32'(alu_b), 32'd0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dcount++;
        end
        chk("midrst:no_done_pulse", 32'(dcount), 32'd0);
        last_prod = '0;
        last_zero = 1'b0;
        last_neg = 1'b0;
        run_op(16'd3, 16'd5, 1'b0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
